// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch front end.
package prefetch_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} pf_state_t;

    localparam int         WORD_BYTES     = 4;
    localparam int         PC_READ_OFFSET = 8;
    localparam logic [3:0] COND_AL        = 4'hE;
    localparam logic [1:0] OP_BRANCH      = 2'b10;

endpackage

// File: rtl/prefetch_queue.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of {inst, pc, pred}.
// Flush clears pointers and count and overrides push/pop in the same cycle.
// Head outputs read as zero while empty so stale storage never leaks out.
module prefetch_queue #(
    parameter int BUS   = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [BUS-1:0]               push_inst,
    input  logic [BUS-1:0]               push_pc,
    input  logic                         push_pred,
    output logic [BUS-1:0]               head_inst,
    output logic [BUS-1:0]               head_pc,
    output logic                         head_pred,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [BUS-1:0] mem_inst [DEPTH];
    logic [BUS-1:0] mem_pc   [DEPTH];
    logic           mem_pred [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic           push_ok, pop_ok;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign push_ok = push & ~full  & ~flush;
    assign pop_ok  = pop  & ~empty & ~flush;

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observable through the empty-gated head.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_inst[wr_ptr] <= push_inst;
            mem_pc[wr_ptr]   <= push_pc;
            mem_pred[wr_ptr] <= push_pred;
        end
    end

    assign head_inst = empty ? '0   : mem_inst[rd_ptr];
    assign head_pc   = empty ? '0   : mem_pc[rd_ptr];
    assign head_pred = empty ? 1'b0 : mem_pred[rd_ptr];

endmodule

// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch unit: PC sequencer + prefetch queue + req/ack imem port.
// Optional feature macro: PREFETCH_PREDECODE_EN (follow unconditional B at fetch).
// A redirect flushes the queue; a request already on the bus is finished in DRAIN
// with its response discarded, so at most one request is ever outstanding.
module inst_prefetch_unit
    import prefetch_pkg::*;
#(
    parameter int             BUS      = 32,
    parameter int             DEPTH    = 4,
    parameter logic [BUS-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [BUS-1:0]             imem_addr,
    input  logic                       imem_ack,
    input  logic [BUS-1:0]             imem_rdata,
    input  logic                       redirect,
    input  logic [BUS-1:0]             redirect_pc,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [BUS-1:0]             inst,
    output logic [BUS-1:0]             inst_pc,
    output logic [BUS-1:0]             inst_pc8,
    output logic                       inst_pred,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] LAST_FREE = CW'(DEPTH-1);

    pf_state_t      state, state_nxt;
    logic [BUS-1:0] fetch_pc, drain_addr, seq_pc, next_pc;
    logic           push, pop, push_pred, q_full, q_empty;

    assign push       = (state == FETCH) & imem_ack & ~redirect;
    assign inst_valid = ~q_empty;
    assign pop        = inst_valid & inst_ready & ~redirect;
    assign seq_pc     = fetch_pc + BUS'(WORD_BYTES);

`ifdef PREFETCH_PREDECODE_EN
    logic           is_b, pred_pending;
    logic [BUS-1:0] b_target;

    assign is_b     = (imem_rdata[31:28] == COND_AL) && (imem_rdata[27:26] == OP_BRANCH)
                      && (imem_rdata[25:24] == 2'b10);
    assign b_target = fetch_pc + BUS'(PC_READ_OFFSET)
                      + {{(BUS-26){imem_rdata[23]}}, imem_rdata[23:0], 2'b00};
    assign next_pc   = is_b ? b_target : seq_pc;
    assign push_pred = pred_pending;

    // Tag the entry fetched right after a followed branch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          pred_pending <= 1'b0;
        else if (redirect) pred_pending <= 1'b0;
        else if (push)     pred_pending <= is_b;
    end
`else
    assign next_pc   = seq_pc;
    assign push_pred = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: fill until full, park in FULL, drain a stale request after redirect.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                if (redirect)
                    state_nxt = imem_ack ? FETCH : DRAIN;
                else if (push && !pop && q_count == LAST_FREE)
                    state_nxt = FULL;
            end
            FULL:  if (redirect || pop) state_nxt = FETCH;
            DRAIN: if (imem_ack) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // Fetch PC and the address held on the bus while draining.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc   <= RESET_PC;
            drain_addr <= RESET_PC;
        end else begin
            if (state == FETCH && redirect && !imem_ack)
                drain_addr <= fetch_pc;
            if (redirect)
                fetch_pc <= {redirect_pc[BUS-1:2], 2'b00};
            else if (push)
                fetch_pc <= next_pc;
        end
    end

    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = (state == DRAIN) ? drain_addr : fetch_pc;
    assign inst_pc8  = inst_pc + BUS'(PC_READ_OFFSET);

    prefetch_queue #(.BUS(BUS), .DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_inst (imem_rdata),
        .push_pc   (fetch_pc),
        .push_pred (push_pred),
        .head_inst (inst),
        .head_pc   (inst_pc),
        .head_pred (inst_pred),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    logic unused_ok;
    assign unused_ok = q_full;

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Directed bench for inst_prefetch_unit (DEPTH=4, RESET_PC=0).
// Memory returns 0xA000_0000 | addr, except 0xEA000002 at 0x40 when br_at_40 is set.
module tb_inst_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack, redirect, inst_valid, inst_ready, inst_pred;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc, inst_pc8;
    logic [2:0]  q_count;
    logic        br_at_40;
    int          n_chk = 0;
    int          n_pass = 0;

`ifdef PREFETCH_PREDECODE_EN
    localparam logic [31:0] EXP_NEXT = 32'h50;
    localparam logic [31:0] EXP_PRED = 32'h1;
`else
    localparam logic [31:0] EXP_NEXT = 32'h44;
    localparam logic [31:0] EXP_PRED = 32'h0;
`endif

    inst_prefetch_unit #(.BUS(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_pc8(inst_pc8), .inst_pred(inst_pred), .q_count(q_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (br_at_40 && imem_addr == 32'h40) imem_rdata = 32'hEA00_0002;
        else                                 imem_rdata = 32'hA000_0000 | imem_addr;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b0; imem_ack = 1'b0; redirect = 1'b0; redirect_pc = '0;
        inst_ready = 1'b0; br_at_40 = 1'b0;
        #12;
        chk("rst_req",   {31'b0, imem_req},   0);
        chk("rst_addr",  imem_addr,           0);
        chk("rst_valid", {31'b0, inst_valid}, 0);
        chk("rst_inst",  inst,                0);
        chk("rst_pc",    inst_pc,             0);
        chk("rst_pc8",   inst_pc8,            8);
        chk("rst_pred",  {31'b0, inst_pred},  0);
        chk("rst_cnt",   {29'b0, q_count},    0);

        // zero-wait streaming
        rst = 1'b1; imem_ack = 1'b1; inst_ready = 1'b1;
        step();
        chk("idle_fetch_req", {31'b0, imem_req}, 1);
        chk("first_addr",     imem_addr,         0);
        chk("first_valid_lo", {31'b0, inst_valid}, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stream_valid", {31'b0, inst_valid}, 1);
            chk("stream_pc",    inst_pc,  32'(4 * i));
            chk("stream_pc8",   inst_pc8, 32'(4 * i + 8));
            chk("stream_inst",  inst,     32'hA000_0000 | 32'(4 * i));
            chk("stream_cnt",   {29'b0, q_count}, 1);
        end

        // back-pressure fills queue, one pop re-arms fetch
        inst_ready = 1'b0;
        step(); step(); step();
        chk("full_cnt",  {29'b0, q_count},  4);
        chk("full_req",  {31'b0, imem_req}, 0);
        chk("full_head", inst_pc,           32'hC);
        step();
        chk("full_hold_cnt", {29'b0, q_count},  4);
        chk("full_hold_req", {31'b0, imem_req}, 0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("rearm_req",  {31'b0, imem_req}, 1);
        chk("rearm_addr", imem_addr,         32'h1C);
        chk("rearm_cnt",  {29'b0, q_count},  3);
        chk("rearm_head", inst_pc,           32'h10);

        // redirect + ack + pop in one cycle
        inst_ready = 1'b1; imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h13;
        step();
        redirect = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
        chk("rdack_cnt",   {29'b0, q_count},    0);
        chk("rdack_valid", {31'b0, inst_valid}, 0);
        chk("rdack_addr",  imem_addr,           32'h10);
        chk("rdack_req",   {31'b0, imem_req},   1);
        chk("rdack_pc8",   inst_pc8,            8);

        // three wait states at 0x10
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_addr", imem_addr,         32'h10);
            chk("wait_req",  {31'b0, imem_req}, 1);
            chk("wait_cnt",  {29'b0, q_count},  0);
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("wait_push_cnt",  {29'b0, q_count}, 1);
        chk("wait_push_pc",   inst_pc,          32'h10);
        chk("wait_push_inst", inst,             32'hA000_0010);
        chk("wait_next_addr", imem_addr,        32'h14);
        step();
        chk("wait_one_entry", {29'b0, q_count}, 1);

        // redirect to 0x100 while 0x20 is outstanding
        redirect = 1'b1; redirect_pc = 32'h20; imem_ack = 1'b1;
        step();
        redirect = 1'b0; imem_ack = 1'b0;
        step();
        chk("pend_addr", imem_addr, 32'h20);
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("drain_addr", imem_addr,         32'h20);
        chk("drain_req",  {31'b0, imem_req}, 1);
        chk("drain_cnt",  {29'b0, q_count},  0);
        step();
        chk("drain_hold", imem_addr, 32'h20);
        imem_ack = 1'b1;
        step();
        chk("drain_drop_cnt", {29'b0, q_count}, 0);
        chk("drain_new_addr", imem_addr,        32'h100);
        step();
        imem_ack = 1'b0;
        chk("redir_pc",   inst_pc,            32'h100);
        chk("redir_inst", inst,               32'hA000_0100);
        chk("redir_cnt",  {29'b0, q_count},   1);

        // predecode of unconditional B at 0x40
        redirect = 1'b1; redirect_pc = 32'h40; imem_ack = 1'b1; br_at_40 = 1'b1;
        step();
        redirect = 1'b0;
        chk("b_addr", imem_addr, 32'h40);
        step();
        chk("b_pc",      inst_pc,           32'h40);
        chk("b_inst",    inst,              32'hEA00_0002);
        chk("b_pred",    {31'b0, inst_pred}, 0);
        chk("b_next",    imem_addr,         EXP_NEXT);
        step();
        imem_ack = 1'b0; inst_ready = 1'b1;
        chk("b_cnt", {29'b0, q_count}, 2);
        step();
        inst_ready = 1'b0; br_at_40 = 1'b0;
        chk("b_tgt_pc",   inst_pc,            EXP_NEXT);
        chk("b_tgt_pred", {31'b0, inst_pred}, EXP_PRED);
        chk("b_tgt_cnt",  {29'b0, q_count},   1);

        // address wrap-around
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b1;
        step();
        redirect = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        imem_ack = 1'b0;
        chk("wrap_pc",   inst_pc,   32'hFFFF_FFFC);
        chk("wrap_pc8",  inst_pc8,  32'h4);
        chk("wrap_next", imem_addr, 32'h0);

        // reset mid-transaction
        step();
        chk("pre_rst_req", {31'b0, imem_req}, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_req",   {31'b0, imem_req},   0);
        chk("mid_rst_addr",  imem_addr,           0);
        chk("mid_rst_cnt",   {29'b0, q_count},    0);
        chk("mid_rst_valid", {31'b0, inst_valid}, 0);
        chk("mid_rst_pc8",   inst_pc8,            8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
